// File: rtl/lsu_mem_stage_pkg.sv
// lsu_mem_stage_pkg: shared funct3 size codes, FSM state enum and MEM_TOP default for the LSU memory stage
package lsu_mem_stage_pkg;
    localparam logic [31:0] MEM_TOP_DEF = 32'h3FC;
    localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR} state_t;
    function automatic logic f3_ok(input logic we, input logic [2:0] f3);
        return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                  : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    endfunction
endpackage

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: request, response and data-memory signals of the LSU memory stage
interface lsu_mem_stage_if;
    logic req_valid, req_ready, req_we;
    logic [2:0] req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0] req_rd;
    logic rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [4:0] rsp_rd;
    logic mem_ce, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, rsp_rd, mem_ce, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, rsp_rd, mem_ce, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte/halfword lane extract+extend (MERGE=0) or lane merge into a word (MERGE=1)
module lsu_lane_align import lsu_mem_stage_pkg::*; #(
    parameter bit MERGE = 1'b0
) (
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] data,
    output logic [31:0] result
);
    logic [4:0] sh;
    logic [31:0] mask;
    logic [15:0] lane;
    logic sx;
    always_comb begin
        sh = funct3[1:0] == SZ_B ? {off, 3'b000} : funct3[1:0] == SZ_H ? {off[1], 4'b0000} : 5'd0;
        mask = funct3[1:0] == SZ_B ? 32'hFF << sh : funct3[1:0] == SZ_H ? 32'hFFFF << sh : 32'hFFFF_FFFF;
        lane = 16'((word & mask) >> sh);
        sx = ~funct3[2] & (funct3[1:0] == SZ_B ? lane[7] : lane[15]);
        result = MERGE ? (word & ~mask) | ((data << sh) & mask)
               : funct3[1:0] == SZ_B ? {{24{sx}}, lane[7:0]}
               : funct3[1:0] == SZ_H ? {{16{sx}}, lane} : word;
    end
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32I load/store memory stage with sub-word read-modify-write;
// define LSU_MISALIGN_TRAP_EN to drop misaligned halfword/word accesses with rsp_err.
module lsu_mem_stage import lsu_mem_stage_pkg::*; #(
    parameter logic [31:0] MEM_TOP = MEM_TOP_DEF
) (
    input logic clk,
    input logic rst,
    lsu_mem_stage_if.slave bus
);
    state_t state, state_n;
    logic we_q;
    logic [2:0] f3_q;
    logic [31:0] addr_q, wdata_q, merged_q, load_ext, merged, aligned;
    logic [4:0] rd_q;
    logic accept, drop, misalign;
    assign aligned = {addr_q[31:2], 2'b00};
    assign accept = state == S_IDLE && bus.req_valid;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (bus.req_funct3[1:0] == SZ_H && bus.req_addr[0])
                   || (bus.req_funct3[1:0] == SZ_W && bus.req_addr[1:0] != 2'b00);
`else
    // a halfword at offset 3 would straddle two words, which one RMW cannot cover
    assign misalign = bus.req_we && bus.req_funct3[1:0] == SZ_H && bus.req_addr[1:0] == 2'b11;
`endif
    assign drop = bus.req_addr > MEM_TOP || !f3_ok(bus.req_we, bus.req_funct3) || misalign;
    lsu_lane_align #(.MERGE(1'b0)) u_load (
        .funct3(f3_q), .off(addr_q[1:0]), .word(bus.mem_rdata), .data('0), .result(load_ext)
    );
    lsu_lane_align #(.MERGE(1'b1)) u_merge (
        .funct3(f3_q), .off(addr_q[1:0]), .word(bus.mem_rdata), .data(wdata_q), .result(merged)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        bus.req_ready = 1'b0;
        bus.mem_ce = 1'b0;
        bus.mem_we = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wdata = '0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (accept && !drop)
                    state_n = !bus.req_we ? S_LOAD : bus.req_funct3[1:0] == SZ_W ? S_STORE : S_RMW_RD;
            end
            S_LOAD: begin
                bus.mem_ce = 1'b1;
                bus.mem_addr = f3_q[1:0] == SZ_W ? addr_q : aligned;
                state_n = S_IDLE;
            end
            S_STORE: begin
                bus.mem_ce = 1'b1;
                bus.mem_we = 1'b1;
                bus.mem_addr = addr_q;
                bus.mem_wdata = wdata_q;
                state_n = S_IDLE;
            end
            S_RMW_RD: begin
                bus.mem_ce = 1'b1;
                bus.mem_addr = aligned;
                state_n = S_RMW_WR;
            end
            S_RMW_WR: begin
                bus.mem_ce = 1'b1;
                bus.mem_we = 1'b1;
                bus.mem_addr = aligned;
                bus.mem_wdata = merged_q;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            we_q <= 1'b0;
            f3_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            rd_q <= '0;
            merged_q <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_rd <= '0;
        end else begin
            if (accept) begin
                we_q <= bus.req_we;
                f3_q <= bus.req_funct3;
                addr_q <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                rd_q <= bus.req_rd;
            end
            if (state == S_RMW_RD) merged_q <= merged;
            bus.rsp_valid <= (accept && drop) || state == S_LOAD || state == S_STORE || state == S_RMW_WR;
            bus.rsp_err <= accept && drop;
            bus.rsp_rdata <= state == S_LOAD ? load_ext : '0;
            bus.rsp_rd <= state == S_LOAD && !we_q ? rd_q : '0;
        end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: scoreboard bench for lsu_mem_stage with a byte-array memory and a reference model
module tb_lsu_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_stage_if bus();
    lsu_mem_stage #(.MEM_TOP(32'h3FC)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic err;
        logic [31:0] rdata;
        logic [4:0] rd;
        int lag;
        int ce;
        int wr;
        int acc;
    } exp_t;
    exp_t sbq[$];

    logic [7:0] mem [0:1023];
    logic [7:0] ref_mem [0:1023];
    int total = 0, bad = 0, cyc = 0, ce_cnt = 0, wr_cnt = 0;
    logic poke_en = 1'b0;
    logic [9:0] poke_a = '0;
    logic [31:0] poke_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // data memory the DUT talks to: combinational little-endian read, write on posedge
    always_comb begin
        bus.mem_rdata = '0;
        for (int i = 0; i < 4; i++)
            if (bus.mem_addr + 32'(i) < 32'd1024) bus.mem_rdata[8*i +: 8] = mem[10'(bus.mem_addr + 32'(i))];
    end
    always @(posedge clk)
        if (bus.mem_ce && bus.mem_we) begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_addr + 32'(i) < 32'd1024) mem[10'(bus.mem_addr + 32'(i))] <= bus.mem_wdata[8*i +: 8];
        end else if (poke_en) begin
            for (int i = 0; i < 4; i++) mem[poke_a + 10'(i)] <= poke_d[8*i +: 8];
        end

    function automatic logic [31:0] env_word(input int a);
        return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[10'(a + 32'(i))];
        return v;
    endfunction

    initial forever @(posedge clk) cyc++;

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            ce_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (bus.mem_ce) ce_cnt++;
            if (bus.mem_ce && bus.mem_we) wr_cnt++;
            if (bus.rsp_valid) begin
                if (sbq.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
                else begin
                    e = sbq.pop_front();
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_rd", 32'(bus.rsp_rd), 32'(e.rd));
                    chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lag));
                    chk("mem_ce_cycles", 32'(ce_cnt), 32'(e.ce));
                    chk("mem_write_cycles", 32'(wr_cnt), 32'(e.wr));
                end
                ce_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        drain();
        @(negedge clk);
        poke_a = a;
        poke_d = d;
        poke_en = 1'b1;
        for (int i = 0; i < 4; i++) ref_mem[a + 10'(i)] = d[8*i +: 8];
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // lag counts edges from the accept edge (inclusive) to the edge that samples rsp_valid
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input bit force_x = 1'b0, input logic [31:0] xv = '0);
        exp_t e;
        int sz, t;
        logic legal, mis;
        logic [31:0] base;
        sz = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
        legal = we ? f3 <= 3'd2 : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
        mis = sz > 1 && (a % sz) != 0;
`else
        mis = we && sz == 2 && a[1:0] == 2'b11;
`endif
        e.err = a > 32'h3FC || !legal || mis;
        base = sz == 2 ? {a[31:2], a[1], 1'b0} : a;
        e.rdata = '0;
        e.rd = '0;
        e.ce = 0;
        e.wr = 0;
        e.lag = 1;
        if (!e.err) begin
            if (!we) begin
                e.rdata = ref_rd(base, sz);
                if (sz == 1 && !f3[2] && e.rdata[7]) e.rdata |= 32'hFFFF_FF00;
                if (sz == 2 && !f3[2] && e.rdata[15]) e.rdata |= 32'hFFFF_0000;
                e.rd = rd;
                e.ce = 1;
                e.lag = 2;
            end else begin
                for (int i = 0; i < sz; i++) ref_mem[10'(base + 32'(i))] = wd[8*i +: 8];
                e.ce = sz == 4 ? 1 : 2;
                e.wr = 1;
                e.lag = sz == 4 ? 2 : 3;
            end
        end
        if (force_x) e.rdata = xv;
        @(negedge clk);
        bus.req_we = we;
        bus.req_funct3 = f3;
        bus.req_addr = a;
        bus.req_wdata = wd;
        bus.req_rd = rd;
        bus.req_valid = 1'b1;
        t = 0;
        while (!bus.req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t == 20) begin
            chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
        end else begin
            e.acc = cyc;
            sbq.push_back(e);
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] lf [5];
        logic [2:0] f3;
        logic [31:0] a;
        logic we;
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.req_rd = '0;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_mem_ce", 32'(bus.mem_ce), 32'd0);
        chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
        chk("reset_mem_addr", bus.mem_addr, 32'd0);
        chk("reset_mem_wdata", bus.mem_wdata, 32'd0);
        for (int w = 0; w < 1024; w += 4) poke(10'(w), $urandom);
        @(negedge clk);
        rst = 1'b0;

        poke(10'h10, 32'h8899AABB);
        issue(1'b0, 3'b000, 32'h11, 32'h0, 5'd3, 1'b1, 32'hFFFF_FFAA);
        issue(1'b0, 3'b100, 32'h11, 32'h0, 5'd4, 1'b1, 32'h0000_00AA);
        issue(1'b0, 3'b101, 32'h12, 32'h0, 5'd5, 1'b1, 32'h0000_8899);
        poke(10'h0C, 32'h11223344);
        issue(1'b1, 3'b000, 32'h0D, 32'h5A, 5'd0);
        drain();
        chk("sb_merge_word", env_word(32'h0C), 32'h11225A44);
        issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 5'd0);
        issue(1'b0, 3'b010, 32'h20, 32'h0, 5'd7, 1'b1, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h400, 32'h0, 5'd8);
        poke(10'h14, 32'h44332211);
        issue(1'b0, 3'b010, 32'h13, 32'h0, 5'd9);
        issue(1'b1, 3'b001, 32'h17, 32'hBEEF, 5'd0);
        drain();

        poke(10'h40, 32'hCAFEF00D);
        @(negedge clk);
        bus.req_we = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h41;
        bus.req_wdata = 32'h77;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("rmw_wr_mem_we", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mem_we_drop", 32'(bus.mem_we), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_word_kept", env_word(32'h40), 32'hCAFEF00D);
        chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int k = 0; k < 300; k++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else f3 = we ? lf[$urandom_range(0, 2)] : lf[$urandom_range(0, 4)];
            if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, 63));
            else if ($urandom_range(0, 19) == 0) a = 32'h3FD + 32'($urandom_range(0, 2000));
            else a = 32'($urandom_range(0, 1023));
            issue(we, f3, a, $urandom, 5'($urandom));
        end
        drain();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
